enh_demux: RTL and testbench
============================

# enh_demux

Tree-level splitter for the NoC: the downstream counterpart of the arbitrating merge stage. It accepts one valid-tagged word stream from the parent level, steers each word to the left or right child by its route bit, and buffers each branch in a private FIFO. The consumed route bit is shifted out of the word so the child level sees its own route bit in the same position. Per-branch back-pressure comes from the children; a single aggregated `full` goes back to the parent.

## Interface
- `word_width`, 16: total word bits; bit `[word_width-1]` is valid, bit `[word_width-2]` is the route bit, bits `[word_width-3:0]` are payload/remaining address.
- `log_buffer_len`, 3: log2 of the per-branch FIFO depth (DEPTH = 2^log_buffer_len).
- `clk_r`: input, 1 bit, tree-level clock; all state is on its rising edge.
- `rst`: input, 1 bit, reset. Synchronous and active-high.
- `in`: input, `word_width` bits, word from the parent level.
- `full_1`: input, 1 bit, left child cannot accept a word this cycle.
- `full_2`: input, 1 bit, right child cannot accept a word this cycle.
- `out_1`: output, `word_width` bits, registered word to the left child.
- `out_2`: output, `word_width` bits, registered word to the right child.
- `full`: output, 1 bit, registered back-pressure to the parent.
- `ovf`: output, 1 bit, sticky flag that is set when a valid word is dropped.

## Operation
- **Accept.** A word is accepted in any cycle where `in[word_width-1]` is 1. The parent must honour `full`. The block does not stall `in`.
- **Route.** Route bit 0 selects FIFO1, which feeds `out_1`. Route bit 1 selects FIFO2, which feeds `out_2`.
- **Stored word.** The FIFO stores `{in[word_width-3:0], 1'b0}`, which is `word_width-1` bits: the route bit is consumed and the address is shifted left by one.
- **Push.** A push succeeds if the target count is below DEPTH, or if the target FIFO also pops in the same cycle.
- **Drop.** Otherwise the word is discarded, `ovf` is set to 1, and the count is unchanged.
- **Output stage, FIFO1** (FIFO2 is identical with `full_2`/`out_2`):
  - If the count is nonzero and `full_1` is 0: pop, and on the next edge load `out_1 <= {1'b1, head}`.
  - Otherwise: load `out_1 <= {word_width{1'b0}}`.
  - No word is ever presented twice.
- **Counts.** Each FIFO tracks a count from 0 to DEPTH.
  - Pointers are `log_buffer_len` bits and wrap modulo DEPTH.
  - Push+pop in the same cycle leaves the count unchanged; at count = DEPTH, push+pop is legal.
- **`full`.** Registered: `full <= (cnt1_next >= DEPTH-1) | (cnt2_next >= DEPTH-1)`. This leaves one skid slot to absorb the word in flight during the cycle `full` rises.
- **`ovf`.** Cleared only by `rst`.
- **Reset.** `rst` high at an edge sets:
  - `out_1`, `out_2`, `full`, `ovf` to 0;
  - both counts and all pointers to 0.
  - FIFO storage contents are don't-care.
  - A word presented in the reset cycle is discarded and does not set `ovf`.
  - Reset mid-burst discards all buffered words.

## Timing
- **Latency.** A valid word at `in` in cycle n (branch empty, child not full) is written at the end of n. It is popped in n+1 and appears on `out_x` in cycle n+2, so latency is 2 cycles.
- **`full_x` sampling.** `full_x` is sampled in the pop cycle. If `full_x` is high in cycle k, `out_x` carries valid=0 in cycle k+1.
- **Throughput.** One word per cycle per branch. Both branches pop independently in the same cycle.
- **Back-pressure timing.** `full` rises in the cycle after the push that brings either count to DEPTH-1. It falls in the cycle after both counts drop below DEPTH-1.
- **Combinational paths.** There is no combinational path from any input to any output.

## Test plan
Configuration for all scenarios: `word_width`=16, `log_buffer_len`=3 (DEPTH=8).

1. **Single-word routing.**
   - Drive `in`=16'hA123 (valid=1, route=0) in cycle 0 with `full_1`=0. Then `out_1`=16'hC246 in cycle 2, and `out_2` valid stays 0 throughout.
   - Drive `in`=16'hC001 (route=1). Then `out_2`=16'h8002 after 2 cycles.
2. **Alternating stream.**
   - Drive 8 consecutive words alternating route 0/1 with payloads 1..8, both `full_x`=0.
   - `out_1` carries the odd payloads and `out_2` the even payloads, each shifted left by 1.
   - Each branch outputs in arrival order, and each word appears 2 cycles after its input.
3. **Back-pressure and `full`.**
   - Hold `full_1`=1 and push 7 route-0 words. `full`=1 starting the cycle after the 7th push.
   - An 8th push is still accepted, with `ovf`=0.
   - Release `full_1`. The 8 words drain one per cycle in order, and `full` falls after the count reaches 6.
4. **Overflow.**
   - Hold `full_1`=1 and push 9 route-0 words. The 9th is dropped and `ovf`=1 sticks.
   - After release, exactly 8 words emerge.
5. **Full FIFO with push+pop.**
   - With FIFO1 at count 8, deassert `full_1` and push a new route-0 word in the same cycle.
   - The push succeeds, the count stays 8, `ovf` stays 0, and the new word is output last.
6. **Reset mid-operation.**
   - With 5 words buffered in FIFO1, assert `rst` for 1 cycle.
   - Next cycle: `out_1`=`out_2`=0, `full`=0, `ovf`=0.
   - No buffered word ever appears afterwards, and a fresh word routes with 2-cycle latency.

Source files
------------

// File: rtl/enh_demux_if.sv
// Parent/child bus for the enh_demux tree splitter.
// The master side drives the parent word and the child back-pressure;
// the slave side (the splitter) returns both child words, full and ovf.
interface enh_demux_if #(
  parameter int word_width = 16
) ();
  logic [word_width-1:0] in;
  logic                  full_1;
  logic                  full_2;
  logic [word_width-1:0] out_1;
  logic [word_width-1:0] out_2;
  logic                  full;
  logic                  ovf;

  modport master (
    output in,
    output full_1,
    output full_2,
    input  out_1,
    input  out_2,
    input  full,
    input  ovf
  );

  modport slave (
    input  in,
    input  full_1,
    input  full_2,
    output out_1,
    output out_2,
    output full,
    output ovf
  );
endinterface

// File: rtl/enh_demux.sv
// Tree-level splitter: steers each valid parent word to the left or right
// child by its route bit, buffering each branch in a private FIFO. The
// route bit is consumed and the remaining address shifted up one place.
module enh_demux #(
  parameter int word_width     = 16,
  parameter int log_buffer_len = 3
) (
  input logic        clk_r,
  input logic        rst,
  enh_demux_if.slave bus
);

  localparam int DEPTH = 1 << log_buffer_len;
  localparam int CW    = log_buffer_len + 1;

  typedef logic [log_buffer_len-1:0] ptr_t;
  typedef logic [CW-1:0]             cnt_t;
  typedef logic [word_width-2:0]     item_t;

  localparam cnt_t CNT_MAX  = cnt_t'(DEPTH);
  localparam cnt_t CNT_SKID = cnt_t'(DEPTH - 1);

  item_t mem1 [DEPTH];
  item_t mem2 [DEPTH];

  ptr_t rd1, wr1, rd2, wr2;
  cnt_t cnt1, cnt2;
  cnt_t cnt1_next, cnt2_next;

  logic                  in_valid;
  logic                  in_route;
  item_t                 in_item;
  logic                  pop1, pop2;
  logic                  push1, push2;
  logic                  drop;

  logic [word_width-1:0] out_1_q, out_2_q;
  logic                  full_q, ovf_q;

  // Decode the parent word and decide push/pop/drop for both branches.
  always_comb begin
    in_valid = bus.in[word_width-1];
    in_route = bus.in[word_width-2];
    in_item  = {bus.in[word_width-3:0], 1'b0};

    pop1 = (cnt1 != '0) && !bus.full_1;
    pop2 = (cnt2 != '0) && !bus.full_2;

    // A full FIFO still accepts when it also pops this cycle.
    push1 = in_valid && !in_route && ((cnt1 != CNT_MAX) || pop1);
    push2 = in_valid &&  in_route && ((cnt2 != CNT_MAX) || pop2);

    // A valid word targets exactly one FIFO, so no push means it was lost.
    drop = in_valid && !push1 && !push2;

    cnt1_next = cnt1 + cnt_t'(push1) - cnt_t'(pop1);
    cnt2_next = cnt2 + cnt_t'(push2) - cnt_t'(pop2);
  end

  // FIFO storage; contents are don't-care after reset so no reset here.
  always_ff @(posedge clk_r) begin
    if (!rst && push1) mem1[wr1] <= in_item;
    if (!rst && push2) mem2[wr2] <= in_item;
  end

  // Pointers, counts and the registered output stage.
  always_ff @(posedge clk_r) begin
    if (rst) begin
      rd1     <= '0;
      wr1     <= '0;
      rd2     <= '0;
      wr2     <= '0;
      cnt1    <= '0;
      cnt2    <= '0;
      out_1_q <= '0;
      out_2_q <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      cnt1 <= cnt1_next;
      cnt2 <= cnt2_next;
      if (push1) wr1 <= wr1 + ptr_t'(1);
      if (push2) wr2 <= wr2 + ptr_t'(1);
      if (pop1)  rd1 <= rd1 + ptr_t'(1);
      if (pop2)  rd2 <= rd2 + ptr_t'(1);

      out_1_q <= pop1 ? {1'b1, mem1[rd1]} : '0;
      out_2_q <= pop2 ? {1'b1, mem2[rd2]} : '0;

      // Raised one slot early so the word in flight when full rises fits.
      full_q <= (cnt1_next >= CNT_SKID) || (cnt2_next >= CNT_SKID);

      if (drop) ovf_q <= 1'b1;
    end
  end

  assign bus.out_1 = out_1_q;
  assign bus.out_2 = out_2_q;
  assign bus.full  = full_q;
  assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_enh_demux.sv
// Bench for enh_demux: queue-based reference model checked every cycle,
// plus directed scenarios with literal expected values.
module tb_enh_demux;

  localparam int WW    = 16;
  localparam int LBL   = 3;
  localparam int DEPTH = 8;

  logic clk_r = 1'b0;
  logic rst   = 1'b1;

  enh_demux_if #(.word_width(WW)) bus ();

  enh_demux #(.word_width(WW), .log_buffer_len(LBL)) dut (
    .clk_r (clk_r),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clk_r = ~clk_r;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Reference model state: one queue per branch plus expected outputs.
  logic [14:0] q1 [$];
  logic [14:0] q2 [$];
  logic [15:0] e_out1, e_out2;
  logic        e_full, e_ovf;
  logic        m_p1, m_p2;
  logic [14:0] m_w;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model advances on each rising edge from the inputs present at that edge.
  always @(posedge clk_r) begin
    if (rst) begin
      q1.delete();
      q2.delete();
      e_out1 = '0;
      e_out2 = '0;
      e_full = 1'b0;
      e_ovf  = 1'b0;
    end else begin
      m_p1 = (q1.size() != 0) && !bus.full_1;
      m_p2 = (q2.size() != 0) && !bus.full_2;
      e_out1 = m_p1 ? {1'b1, q1.pop_front()} : 16'h0000;
      e_out2 = m_p2 ? {1'b1, q2.pop_front()} : 16'h0000;
      if (bus.in[15]) begin
        m_w = {bus.in[13:0], 1'b0};
        if (!bus.in[14]) begin
          if (q1.size() < DEPTH) q1.push_back(m_w);
          else e_ovf = 1'b1;
        end else begin
          if (q2.size() < DEPTH) q2.push_back(m_w);
          else e_ovf = 1'b1;
        end
      end
      e_full = (q1.size() >= DEPTH - 1) || (q2.size() >= DEPTH - 1);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk_r) begin
    if (chk_en) begin
      check("out_1", bus.out_1, e_out1);
      check("out_2", bus.out_2, e_out2);
      check("full",  16'(bus.full), 16'(e_full));
      check("ovf",   16'(bus.ovf),  16'(e_ovf));
    end
  end

  task automatic drive(input logic [15:0] w, input logic f1, input logic f2);
    @(negedge clk_r);
    bus.in     = w;
    bus.full_1 = f1;
    bus.full_2 = f2;
  endtask

  task automatic do_reset();
    @(negedge clk_r);
    rst        = 1'b1;
    bus.in     = '0;
    bus.full_1 = 1'b0;
    bus.full_2 = 1'b0;
    @(negedge clk_r);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    logic [15:0] last;

    bus.in     = '0;
    bus.full_1 = 1'b0;
    bus.full_2 = 1'b0;
    rst        = 1'b1;
    @(negedge clk_r);
    @(negedge clk_r);
    chk_en = 1'b1;
    check("rst_out1", bus.out_1, 16'h0000);
    check("rst_out2", bus.out_2, 16'h0000);
    check("rst_full", 16'(bus.full), 16'h0000);
    check("rst_ovf",  16'(bus.ovf),  16'h0000);
    rst = 1'b0;

    // Single-word routing, both branches.
    drive(16'hA123, 1'b0, 1'b0);
    drive(16'h0000, 1'b0, 1'b0);
    drive(16'h0000, 1'b0, 1'b0);
    check("t1_out1", bus.out_1, 16'hC246);
    check("t1_out2_idle", bus.out_2, 16'h0000);
    drive(16'hC001, 1'b0, 1'b0);
    drive(16'h0000, 1'b0, 1'b0);
    drive(16'h0000, 1'b0, 1'b0);
    check("t1_out2", bus.out_2, 16'h8002);

    // Alternating stream, payloads 1..8, odd to left, even to right.
    for (int i = 1; i <= 8; i++) begin
      drive({1'b1, 1'(i % 2 == 0), 14'(i)}, 1'b0, 1'b0);
      if (i == 3) check("t2_first_out1", bus.out_1, 16'h8002);
      if (i == 4) check("t2_first_out2", bus.out_2, 16'h8004);
    end
    repeat (3) drive(16'h0000, 1'b0, 1'b0);

    // Back-pressure: 7 pushes raise full, the 8th still fits.
    for (int i = 0; i < 7; i++) drive({2'b10, 14'(16 + i)}, 1'b1, 1'b0);
    drive({2'b10, 14'(23)}, 1'b1, 1'b0);
    check("t3_full_after7", 16'(bus.full), 16'h0001);
    check("t3_ovf_7", 16'(bus.ovf), 16'h0000);
    drive(16'h0000, 1'b1, 1'b0);
    check("t3_ovf_8", 16'(bus.ovf), 16'h0000);
    repeat (12) drive(16'h0000, 1'b0, 1'b0);
    check("t3_full_drained", 16'(bus.full), 16'h0000);

    // Overflow: the 9th word is dropped and ovf sticks.
    for (int i = 0; i < 9; i++) drive({2'b10, 14'(32 + i)}, 1'b1, 1'b0);
    drive(16'h0000, 1'b1, 1'b0);
    check("t4_ovf", 16'(bus.ovf), 16'h0001);
    n = 0;
    repeat (14) begin
      drive(16'h0000, 1'b0, 1'b0);
      if (bus.out_1[15]) n++;
    end
    check("t4_count", 16'(n), 16'd8);
    check("t4_ovf_sticky", 16'(bus.ovf), 16'h0001);

    // Push into a full FIFO in the same cycle it pops.
    do_reset();
    for (int i = 0; i < 8; i++) drive({2'b10, 14'(48 + i)}, 1'b1, 1'b0);
    drive(16'h8155, 1'b0, 1'b0);
    drive(16'h0000, 1'b0, 1'b0);
    check("t5_ovf", 16'(bus.ovf), 16'h0000);
    last = '0;
    n    = 0;
    repeat (12) begin
      drive(16'h0000, 1'b0, 1'b0);
      if (bus.out_1[15]) begin
        last = bus.out_1;
        n++;
      end
    end
    check("t5_last", last, 16'h82AA);
    check("t5_count", 16'(n), 16'd8);

    // Reset mid-burst with a valid word on the input in the reset cycle.
    for (int i = 0; i < 5; i++) drive({2'b10, 14'(64 + i)}, 1'b1, 1'b0);
    @(negedge clk_r);
    rst        = 1'b1;
    bus.in     = 16'hA0FF;
    bus.full_1 = 1'b0;
    @(negedge clk_r);
    rst    = 1'b0;
    bus.in = '0;
    check("t6_out1", bus.out_1, 16'h0000);
    check("t6_out2", bus.out_2, 16'h0000);
    check("t6_full", 16'(bus.full), 16'h0000);
    check("t6_ovf",  16'(bus.ovf),  16'h0000);
    drive(16'hC00F, 1'b0, 1'b0);
    drive(16'h0000, 1'b0, 1'b0);
    drive(16'h0000, 1'b0, 1'b0);
    check("t6_fresh", bus.out_2, 16'h801E);
    n = 0;
    repeat (10) begin
      drive(16'h0000, 1'b0, 1'b0);
      if (bus.out_1[15]) n++;
    end
    check("t6_no_stale", 16'(n), 16'd0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
